ysyx_22040127_seq_divider: RTL

- Multi-cycle radix-2 restoring divider; the responder side of the execute stage's divide request/ready handshake.
- Serves DIV/DIVU/REM/REMU and their W variants. The execute stage sign- or zero-extends W operands to 64 bits before presenting them.
- Returns the quotient and remainder together. One request is in flight at a time.

---
 rtl/ysyx_22040127_seq_divider.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040127_seq_divider.sv
// Radix-2 restoring divider serving the execute stage's divide handshake.
// Produces one quotient bit per cycle on magnitudes and fixes the signs on entry to DONE.
module ysyx_22040127_seq_divider #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             div_signed,
   input  logic             div_req,
   input  logic             div_hold,
   input  logic             div_cancel,
   output logic             div_ready,
   output logic [1:0]       div_state,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t state;
   state_t next_state;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] p_q;
   logic             q_neg;
   logic             r_neg;

   logic             div_zero;
   logic             last_iter;
   logic             dvd_neg;
   logic             dsr_neg;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_diff;
   logic             q_bit;
   logic [WIDTH-1:0] p_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;

   assign div_zero  = (divisor == '0);
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign dvd_neg   = div_signed & dividend[WIDTH-1];
   assign dsr_neg   = div_signed & divisor[WIDTH-1];
   assign dvd_abs   = dvd_neg ? -dividend : dividend;
   assign dsr_abs   = dsr_neg ? -divisor : divisor;

   // The dividend register shifts left each step and the new quotient bit enters at the LSB,
   // so after WIDTH steps it holds the unsigned quotient. A clear borrow means P >= |divisor|.
   assign p_shift = {p_q, dvd_q[WIDTH-1]};
   assign p_diff  = p_shift - {1'b0, dsr_q};
   assign q_bit   = ~p_diff[WIDTH];
   assign p_next  = q_bit ? p_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
   assign q_next  = {dvd_q[WIDTH-2:0], q_bit};
   assign q_final = q_neg ? -q_next : q_next;
   assign r_final = r_neg ? -p_next : p_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (div_cancel) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (div_req) begin
                  next_state = div_zero ? DONE : CALC;
               end
            end
            CALC: begin
               if (last_iter) begin
                  next_state = DONE;
               end
            end
            DONE: begin
               if (!div_hold) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      div_ready = (state == DONE);
      div_state = state;
   end

   // An aborted operation must never touch the visible result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         p_q       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (!div_cancel) begin
         case (state)
            IDLE: begin
               if (div_req) begin
                  if (div_zero) begin
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     dvd_q <= dvd_abs;
                     dsr_q <= dsr_abs;
                     p_q   <= '0;
                     cnt   <= '0;
                     q_neg <= dvd_neg ^ dsr_neg;
                     r_neg <= dvd_neg;
                  end
               end
            end
            CALC: begin
               dvd_q <= q_next;
               p_q   <= p_next;
               cnt   <= cnt + CNT_W'(1);
               if (last_iter) begin
                  quotient  <= q_final;
                  remainder <= r_final;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
